labelchange_regfile: RTL
========================

# labelchange_regfile

Parametrised successor to the single dynamic-label register. Holds DEPTH entries of WIDTH bits, each carrying its own 1-bit security label (L=0, H=1). Supports labelled writes, in-place relabelling (downgrade erases data), label-checked registered reads, and a multi-cycle scrub that erases every H entry. Sits between producers of mixed-sensitivity data and public/secret consumers, so no H data is ever observed at an L read.

## Interface
Parameters:
- WIDTH, 8, data bits per entry (≥1)
- DEPTH, 4, number of entries (≥2, power of two)
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  reset, synchronous and active-high
- op  in  2  entry operation: 00 NOP, 01 WRITE, 10 RELABEL, 11 reserved (treated as NOP)
- op_addr  in  AW  target entry for op
- op_lbl  in  1  label for WRITE / new label for RELABEL
- op_data  in  WIDTH  write data (WRITE only)
- op_ready  out  1  high when op is accepted this cycle (= !busy)
- scrub  in  1  request scrub of all H entries (pulse)
- busy  out  1  scrub in progress
- r_en  in  1  read request
- r_addr  in  AW  read entry
- r_lbl  in  1  reader clearance
- r_data  out  WIDTH  read result, registered
- r_valid  out  1  r_data valid, one cycle after r_en
- r_denied  out  1  read refused by label check (r_data forced 0)

## Operation
- Entry state: data[i] (WIDTH), lbl[i] (1). Reset: all data 0, all lbl L.
- WRITE (op=01, op_ready=1): data[op_addr] ← op_data, lbl[op_addr] ← op_lbl.
- RELABEL (op=10, op_ready=1):
  - L→H or same label: lbl updated, data kept.
  - H→L: lbl ← L, data ← 0 in the same update (no H data ever held under L).
- op presented while busy=1: ignored, no state change; op_ready=0 tells the source to hold.
- Read: if r_en, then next cycle r_valid=1; if r_lbl ≥ lbl[r_addr] then r_data=data[r_addr], r_denied=0; else r_data=0, r_denied=1. If r_en=0, next cycle r_valid=0, r_data=0, r_denied=0.
- Read and op to the same entry in the same cycle: read returns pre-update data and label (read-before-write).
- Reads are accepted during scrub and see the current (partially scrubbed) state.
- Scrub FSM:
  - IDLE: scrub=1 and no rst → SCRUB, idx ← 0, busy=1 from the next cycle.
  - SCRUB: each cycle, if lbl[idx]=H then data[idx] ← 0 and lbl[idx] ← L. idx increments; after idx=DEPTH-1 → IDLE.
  - scrub asserted while in SCRUB is ignored (no restart).
  - An op arriving in the same cycle scrub is sampled in IDLE is accepted, since op_ready=1 that cycle, and completes before the scrub visits the entry.
- rst mid-scrub: FSM → IDLE, idx → 0, all entries cleared as at reset.

## Timing
- Reset values (cycle after rst is sampled high): busy=0, op_ready=1, r_valid=0, r_data=0, r_denied=0, all entries 0/L.
- WRITE/RELABEL: effective at the clock edge where accepted; visible to a read issued the following cycle.
- Read latency: 1 cycle, fully registered outputs.
- Scrub duration: exactly DEPTH cycles of busy=1; op_ready low for the same DEPTH cycles.
- idx wrap: idx is AW bits; the terminal compare on DEPTH-1 ends the scrub, so no wrap to 0 is ever used as an entry.

## Structure
- Shared header labelchange_defs.vh: LBL_L=1'b0, LBL_H=1'b1, OP_NOP/OP_WRITE/OP_RELABEL/OP_RSVD codes, FSM state encodings S_IDLE/S_SCRUB.
- Sub-module lbl_entry (WIDTH): one data+label register with write, relabel and scrub-clear inputs; implements the downgrade-erase rule locally. The top module instantiates it DEPTH times via generate, and contains the scrub FSM and the read/label-check register.

## Test plan
- Reset, then read every entry with r_lbl=L → r_valid=1, r_data=0, r_denied=0 for all.
- WRITE addr 2, lbl H, data 0xA5; read addr 2 with r_lbl=L → r_data=0, r_denied=1; with r_lbl=H → r_data=0xA5, r_denied=0.
- WRITE addr 1, lbl L, data 0x3C; RELABEL addr 1 to H; read with r_lbl=H → 0x3C. RELABEL back to L; read with r_lbl=L → 0x00, r_denied=0.
- Entries 0=H/0x11, 1=L/0x22, 2=H/0x33, 3=L/0x44; pulse scrub → busy high for 4 cycles, op_ready=0, WRITE during scrub ignored; afterwards all entries are L with data 00, 22, 00, 44.
- Same-cycle WRITE addr 3 = 0x77 and read addr 3 → r_data is the old value; a read the next cycle returns 0x77.
- Scrub started, rst asserted on its 2nd cycle → next cycle busy=0, all entries 0/L, outputs at reset values.

Source files
------------

// File: rtl/labelchange_regfile_pkg.sv
// Shared labels, op codes and scrub FSM states for the labelled register file.
package labelchange_regfile_pkg;

  localparam logic LBL_L = 1'b0;
  localparam logic LBL_H = 1'b1;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_RELABEL = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SCRUB = 1'b1
  } state_e;

endpackage

// File: rtl/labelchange_regfile_lbl_entry.sv
// One data+label register; a downgrade to L erases the data in the same update.
module labelchange_regfile_lbl_entry
  import labelchange_regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_lbl,
  input  logic             rl_en,
  input  logic             rl_lbl,
  input  logic             clr_h,
  output logic [WIDTH-1:0] data,
  output logic             lbl
);

  // Entry update: write, relabel (erase on H->L), or scrub-clear of an H entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      lbl  <= LBL_L;
    end else if (wr_en) begin
      data <= wr_data;
      lbl  <= wr_lbl;
    end else if (rl_en) begin
      if (lbl == LBL_H && rl_lbl == LBL_L) begin
        data <= '0;
      end
      lbl <= rl_lbl;
    end else if (clr_h && lbl == LBL_H) begin
      data <= '0;
      lbl  <= LBL_L;
    end
  end

endmodule

// File: rtl/labelchange_regfile.sv
// Labelled register file with label-checked registered reads and an H-entry scrub.
module labelchange_regfile
  import labelchange_regfile_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    op_addr,
  input  logic             op_lbl,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  input  logic             scrub,
  output logic             busy,
  input  logic             r_en,
  input  logic [AW-1:0]    r_addr,
  input  logic             r_lbl,
  output logic [WIDTH-1:0] r_data,
  output logic             r_valid,
  output logic             r_denied
);

  state_e        state_q, state_n;
  logic [AW-1:0] idx_q, idx_n;
  logic          busy_n, ready_n;
  logic          op_wr, op_rl;

  logic [WIDTH-1:0] ent_data [DEPTH];
  logic             ent_lbl  [DEPTH];

  // Op decode; ops only take effect while the scrub is not running.
  always_comb begin
    op_wr = 1'b0;
    op_rl = 1'b0;
    case (op)
      OP_WRITE:        op_wr = op_ready;
      OP_RELABEL:      op_rl = op_ready;
      OP_NOP, OP_RSVD: ;
      default:         ;
    endcase
  end

  // Entry array; the scrub clears only the entry currently indexed.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic sel;
    assign sel = (op_addr == AW'(i));

    labelchange_regfile_lbl_entry #(.WIDTH(WIDTH)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (op_wr && sel),
      .wr_data (op_data),
      .wr_lbl  (op_lbl),
      .rl_en   (op_rl && sel),
      .rl_lbl  (op_lbl),
      .clr_h   ((state_q == S_SCRUB) && (idx_q == AW'(i))),
      .data    (ent_data[i]),
      .lbl     (ent_lbl[i])
    );
  end

  // Scrub FSM state, index and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      busy     <= 1'b0;
      op_ready <= 1'b1;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      busy     <= busy_n;
      op_ready <= ready_n;
    end
  end

  // Scrub next-state: walk every index once, ending on the terminal compare.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    busy_n  = 1'b0;
    ready_n = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (scrub) begin
          state_n = S_SCRUB;
          idx_n   = '0;
          busy_n  = 1'b1;
          ready_n = 1'b0;
        end
      end
      S_SCRUB: begin
        if (idx_q == AW'(DEPTH - 1)) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else begin
          idx_n   = idx_q + AW'(1);
          busy_n  = 1'b1;
          ready_n = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // Registered read with label check; sees pre-update entry contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_denied <= 1'b0;
    end else begin
      r_valid  <= r_en;
      r_denied <= r_en && (r_lbl < ent_lbl[r_addr]);
      if (r_en && (r_lbl >= ent_lbl[r_addr])) begin
        r_data <= ent_data[r_addr];
      end else begin
        r_data <= '0;
      end
    end
  end

endmodule
